// File: rtl/bram_pkg.sv
// Shared types for the BRAM DMA engine: FSM states and transfer mode encodings.
package bram_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdGap,
      StWr,
      StFinish
   } dma_state_e;

   typedef enum logic {
      ModeCopy = 1'b0,
      ModeFill = 1'b1
   } dma_mode_e;

endpackage

// File: rtl/dma_timeout_ctr.sv
// Read wait counter: counts enabled cycles and flags the last permitted wait cycle.
module dma_timeout_ctr #(
   parameter int unsigned Limit = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(Limit + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High while the counter sits on the Limit-th wait cycle.
   assign expired_o = (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/bram_dma_engine.sv
// Byte-wide DMA engine: copies or fills a memory region through a single-port
// handshake interface, with read timeout detection.
module bram_dma_engine
   import bram_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode,
   input  logic [15:0] src_addr,
   input  logic [15:0] dst_addr,
   input  logic [15:0] length,
   input  logic [7:0]  fill_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_dr
);

   dma_state_e  state_q, state_d;
   dma_mode_e   mode_q, mode_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  fill_q, fill_d;
   logic [7:0]  data_q, data_d;
   logic        error_q, error_d;
   logic        wait_clr, wait_en, wait_expired;

   assign wait_clr = (state_q != StRdReq) || mem_dr;
   assign wait_en  = (state_q == StRdReq) && !mem_dr;

   dma_timeout_ctr #(
      .Limit(TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wait_clr),
      .en_i      (wait_en),
      .expired_o (wait_expired)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      data_d  = data_q;
      error_d = error_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d  = dma_mode_e'(mode);
               src_d   = src_addr;
               dst_d   = dst_addr;
               cnt_d   = length;
               fill_d  = fill_data;
               error_d = 1'b0;
               if (length == 16'd0) begin
                  state_d = StFinish;
               end else if (mode == ModeFill) begin
                  state_d = StWr;
               end else begin
                  state_d = StRdReq;
               end
            end
         end
         StRdReq: begin
            if (mem_dr) begin
               data_d  = mem_rdata;
               state_d = StRdGap;
            end else if (wait_expired) begin
               error_d = 1'b1;
               state_d = StFinish;
            end
         end
         StRdGap: state_d = StWr;
         StWr: begin
            cnt_d = cnt_q - 16'd1;
            dst_d = dst_q + 16'd1;
            if (mode_q == ModeCopy) begin
               src_d = src_q + 16'd1;
            end
            if (cnt_q == 16'd1) begin
               state_d = StFinish;
            end else if (mode_q == ModeFill) begin
               state_d = StWr;
            end else begin
               state_d = StRdReq;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= ModeCopy;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= '0;
         data_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         error_q <= error_d;
      end
   end

   // Outputs decode from state only, so reset clears them without waiting for a clock.
   always_comb begin
      busy      = (state_q == StRdReq) || (state_q == StRdGap) || (state_q == StWr);
      done      = (state_q == StFinish);
      error     = error_q;
      mem_cs    = (state_q == StRdReq) || (state_q == StWr);
      mem_we    = (state_q == StWr);
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      if (state_q == StRdReq) begin
         mem_addr = src_q;
      end else if (state_q == StWr) begin
         mem_addr  = dst_q;
         mem_wdata = (mode_q == ModeFill) ? fill_q : data_q;
      end
   end

endmodule

// File: tb/tb_bram_dma_engine.sv
// Directed bench for bram_dma_engine with a one-cycle-latency memory responder.
module tb_bram_dma_engine;

   localparam int unsigned Timeout = 15;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [15:0] length;
   logic [7:0]  fill_data;
   logic        busy, done, error;
   logic        mem_cs, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_dr;

   logic [7:0]  rom  [0:65535];
   logic [7:0]  wmem [0:65535];
   logic [15:0] wlog_a [$];
   logic [7:0]  wlog_d [$];
   int          wlog_c [$];
   logic [15:0] rlog   [$];
   int          cyc;
   int          cs_cnt;
   logic        prev_rd;
   logic        dr_en;
   logic        rd_now;

   int n_checks;
   int n_pass;

   bram_dma_engine #(
      .TIMEOUT(Timeout)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .length    (length),
      .fill_data (fill_data),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_dr    (mem_dr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rd_now = mem_cs && !mem_we;

   // Memory responder: data-ready one cycle after a read select, dropped when cs falls.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      prev_rd <= rd_now;
      if (mem_cs) cs_cnt <= cs_cnt + 1;
      if (rd_now && !prev_rd) rlog.push_back(mem_addr);
      if (mem_cs && mem_we) begin
         wmem[mem_addr] <= mem_wdata;
         wlog_a.push_back(mem_addr);
         wlog_d.push_back(mem_wdata);
         wlog_c.push_back(cyc);
      end
      mem_dr    <= dr_en && rd_now;
      mem_rdata <= rom[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic m, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] len, input logic [7:0] f);
      mode      = m;
      src_addr  = s;
      dst_addr  = d;
      length    = len;
      fill_data = f;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run_to_done(input int max, output int busy_cycles);
      int n;
      n = 0;
      busy_cycles = 0;
      while (!done && n < max) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   int base, rbase, csb, bc;
   logic saw_done;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
      length = '0; fill_data = '0; dr_en = 1'b1;
      rom[16'h0010] = 8'h11; rom[16'h0011] = 8'h22; rom[16'h0012] = 8'h33;
      rom[16'hFFFF] = 8'h5A; rom[16'h0000] = 8'hC3; rom[16'h0040] = 8'h99;
      repeat (2) @(negedge clk);
      check("reset_outs", {busy, done, error, mem_cs, mem_we, mem_addr, mem_wdata}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_outs", {busy, done, error, mem_cs, mem_we}, 32'd0);

      // Fill 4 x 0xA5 at 0x1000
      base = wlog_a.size();
      do_start(1'b1, 16'h0000, 16'h1000, 16'd4, 8'hA5);
      check("fill_first_wr", {mem_cs, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h1000, 8'hA5});
      run_to_done(100, bc);
      check("fill_busy_cycles", bc, 32'd4);
      check("fill_finish_outs", {busy, mem_cs, mem_we}, 32'd0);
      check("fill_wr_count", wlog_a.size() - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("fill_addr", {16'd0, wlog_a[base+i]}, 32'h1000 + i);
         check("fill_data", {24'd0, wlog_d[base+i]}, 32'hA5);
         check("fill_b2b", wlog_c[base+i], wlog_c[base] + i);
      end
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // Copy 3 bytes 0x0010 -> 0x2000
      do_start(1'b0, 16'h0010, 16'h2000, 16'd3, 8'h00);
      check("copy_first_rd", {mem_cs, mem_we, mem_addr}, {2'b10, 16'h0010});
      run_to_done(100, bc);
      check("copy_busy_cycles", bc, 32'd12);
      check("copy_b0", {24'd0, wmem[16'h2000]}, 32'h11);
      check("copy_b1", {24'd0, wmem[16'h2001]}, 32'h22);
      check("copy_b2", {24'd0, wmem[16'h2002]}, 32'h33);
      check("copy_err", {31'd0, error}, 32'd0);
      @(negedge clk);

      // Copy across the source wrap
      rbase = rlog.size();
      do_start(1'b0, 16'hFFFF, 16'h8000, 16'd2, 8'h00);
      run_to_done(100, bc);
      check("wrap_rd_count", rlog.size() - rbase, 32'd2);
      check("wrap_rd0", {16'd0, rlog[rbase]}, 32'hFFFF);
      check("wrap_rd1", {16'd0, rlog[rbase+1]}, 32'h0000);
      check("wrap_b0", {24'd0, wmem[16'h8000]}, 32'h5A);
      check("wrap_b1", {24'd0, wmem[16'h8001]}, 32'hC3);
      check("wrap_err", {31'd0, error}, 32'd0);
      @(negedge clk);

      // Zero length
      csb = cs_cnt;
      do_start(1'b1, 16'h0000, 16'h6000, 16'd0, 8'h11);
      check("len0_done", {busy, done}, 32'b01);
      @(negedge clk);
      check("len0_done_drop", {busy, done}, 32'd0);
      check("len0_no_cs", cs_cnt - csb, 32'd0);

      // Read timeout
      dr_en = 1'b0;
      base = wlog_a.size();
      do_start(1'b0, 16'h0040, 16'h7000, 16'd1, 8'h00);
      run_to_done(100, bc);
      check("to_wait_cycles", bc, 32'd15);
      check("to_error", {31'd0, error}, 32'd1);
      check("to_no_write", wlog_a.size() - base, 32'd0);
      @(negedge clk);
      check("to_sticky", {done, error}, 32'b01);
      dr_en = 1'b1;
      do_start(1'b1, 16'h0000, 16'h7100, 16'd1, 8'h42);
      check("to_err_cleared", {31'd0, error}, 32'd0);
      run_to_done(100, bc);
      check("to_next_fill", {24'd0, wmem[16'h7100]}, 32'h42);
      @(negedge clk);

      // Reset during the second write of a fill
      base = wlog_a.size();
      do_start(1'b1, 16'h0000, 16'h3000, 16'd4, 8'h77);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {busy, done, error, mem_cs, mem_we, mem_addr, mem_wdata}, 32'd0);
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw_done |= done;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         saw_done |= done;
      end
      check("rst_no_done", {31'd0, saw_done}, 32'd0);
      check("rst_wr_count", wlog_a.size() - base, 32'd1);

      // New fill; a start while busy is ignored
      base = wlog_a.size();
      do_start(1'b1, 16'h0000, 16'h4000, 16'd3, 8'h3C);
      mode = 1'b0; dst_addr = 16'h5000; length = 16'd9; fill_data = 8'hEE;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_to_done(100, bc);
      check("post_rst_busy", bc, 32'd2);
      check("post_rst_wr_count", wlog_a.size() - base, 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("post_rst_addr", {16'd0, wlog_a[base+i]}, 32'h4000 + i);
         check("post_rst_data", {24'd0, wlog_d[base+i]}, 32'h3C);
      end
      @(negedge clk);
      check("post_rst_idle", {busy, done, mem_cs}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bram_dma_engine.md
BRAM_DMA_ENGINE -- requirements
Module: bram_dma_engine

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum cycles to wait for mem_dr before a read is declared failed.
REQ-002 clk  input  1  single system clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle command strobe.
REQ-005 mode  input  1  0 = copy (read src, write dst), 1 = fill (write fill_data to dst).
REQ-006 src_addr  input  16  copy source base address.
REQ-007 dst_addr  input  16  destination base address.
REQ-008 length  input  16  byte count; 0 = no-op.
REQ-009 fill_data  input  8  fill byte.
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 done  output  1  one-cycle pulse at transfer end, normal or aborted.
REQ-012 error  output  1  read timeout flag; sticky until the next accepted start.
REQ-013 mem_cs, mem_we  output  1 each  memory chip select and write enable.
REQ-014 mem_addr  output  16; mem_wdata  output  8  memory address and write data.
REQ-015 mem_rdata  input  8; mem_dr  input  1  memory read data and data-ready.

Function
REQ-016 start is accepted only in IDLE; at acceptance mode, src_addr, dst_addr, length and fill_data are latched into internal registers, and error is cleared.
REQ-017 start while busy is ignored; a later change to any command input does not affect a running transfer.
REQ-018 States are IDLE, RD_REQ, RD_GAP, WR and FINISH.
REQ-019 Accepting a start with length 0 moves IDLE->FINISH without any memory access.
REQ-020 Accepting a start with length >0 moves IDLE->RD_REQ when mode=0 and IDLE->WR when mode=1.
REQ-021 RD_REQ: drive mem_cs=1, mem_we=0, mem_addr=src pointer, and hold them until mem_dr=1.
REQ-022 On the first cycle mem_dr=1 in RD_REQ, capture mem_rdata into the data register and go to RD_GAP.
REQ-023 RD_GAP: drive mem_cs=0 for exactly one cycle so the memory clears mem_dr, then go to WR.
REQ-024 WR: drive mem_cs=1, mem_we=1, mem_addr=dst pointer and mem_wdata for exactly one cycle.
REQ-025 mem_wdata in WR is the captured byte in copy mode and latched fill_data in fill mode.
REQ-026 After each WR: decrement the remaining count; increment the dst pointer, and in copy mode also the src pointer.
REQ-027 After each WR the next state is FINISH if the count reaches 0, else RD_REQ (copy) or WR (fill).
REQ-028 Minimum cost is 4 cycles per byte in copy mode (RD_REQ x2, RD_GAP, WR) and 1 cycle per byte in fill mode (back-to-back WR).
REQ-029 Pointers are 16 bits and wrap 0xFFFF->0x0000 without error.
REQ-030 Copy is always ascending, with no overlap correction.
REQ-031 A wait counter increments each RD_REQ cycle with mem_dr=0; reaching TIMEOUT sets error, ends the transfer and goes to FINISH.
REQ-032 FINISH: assert done for one cycle with busy=0, mem_cs=0 and mem_we=0, then go to IDLE; a start in FINISH is ignored.
REQ-033 busy is 1 in RD_REQ, RD_GAP and WR, and 0 in IDLE and FINISH.
REQ-034 mem_cs=0 and mem_we=0 in IDLE, RD_GAP and FINISH; mem_we is never 1 while mem_cs=0.

Reset
REQ-035 rst_n low immediately forces IDLE, including mid-transfer, and sets busy, done, error, mem_cs and mem_we to 0, mem_addr to 0x0000, mem_wdata to 0x00, and all pointers and counters to 0.
REQ-036 A transfer interrupted by reset is abandoned, and no done pulse is produced.

Structure
REQ-037 The state enumeration and the mode encodings (COPY=0, FILL=1) live in the shared package bram_pkg.
REQ-038 The timeout wait counter is the sub-module dma_timeout_ctr (clear, enable, expired).

Verification
REQ-039 Fill 4 bytes of 0xA5 from dst 0x1000 -> writes to 0x1000..0x1003 in 4 consecutive cycles, then done, busy high for 4 cycles.
REQ-040 Copy 3 bytes from 0x0010 to 0x2000 with responder model -> dst holds src bytes, done 12 cycles after first RD_REQ.
REQ-041 Copy length 2 from src 0xFFFF to dst 0x8000 -> reads 0xFFFF then 0x0000; no error.
REQ-042 Length 0 start -> done the next cycle, no mem_cs activity.
REQ-043 mem_dr held low, TIMEOUT=15 -> error=1 and done after 15 wait cycles; the next start clears error.
REQ-044 rst_n low during second WR of a fill -> outputs reset immediately, no done; a new start then runs normally; a start during busy is ignored.
